// File: rtl/cfg_chain_loader.sv
`timescale 1ns/1ps
// cfg_chain_loader
// Serializes host bitstream words onto the head of the daisy-chained fabric
// configuration shift registers and reassembles the bits emerging from the
// chain tail into readback words, so one pass both loads the new
// configuration and returns the old one.
//
// Parameters
//   DW         bitstream word width
//   CHAIN_LEN  total chain length in bits (non-zero multiple of DW)
//
// Ports
//   clk       system clock; the chain shifts on rising clk while cfg_en=1
//   rst_n     asynchronous active-low reset
//   start     one-cycle request to begin a full chain load (ignored while busy)
//   s_data    bitstream word, bit DW-1 sent first
//   s_valid   s_data valid
//   s_ready   loader accepts s_data this cycle
//   cfg_si    serial data to chain head (0 whenever cfg_en=0)
//   cfg_en    chain shift enable (feeds the chain clock gate)
//   cfg_so    serial data from chain tail
//   rb_data   readback word, first bit out of the chain in bit DW-1
//   rb_valid  one-cycle pulse, rb_data valid
//   busy      load in progress
//   done      one-cycle pulse, all CHAIN_LEN bits shifted
module cfg_chain_loader #(
    parameter int DW        = 8,
    parameter int CHAIN_LEN = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [DW-1:0] s_data,
    input  logic          s_valid,
    output logic          s_ready,
    output logic          cfg_si,
    output logic          cfg_en,
    input  logic          cfg_so,
    output logic [DW-1:0] rb_data,
    output logic          rb_valid,
    output logic          busy,
    output logic          done
);

    localparam int SW = (DW > 1) ? $clog2(DW) : 1;
    localparam int CW = $clog2(CHAIN_LEN + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        SHIFT = 2'd2,
        FIN   = 2'd3
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;
    logic [DW-1:0]   tx_r;
    logic [DW-1:0]   tx_nxt_s;
    logic [DW-1:0]   rx_r;
    logic [DW:0]     rx_cat_s;
    logic [DW-1:0]   rx_shift_s;
    logic [CW-1:0]   bit_cnt_r;
    logic [SW-1:0]   sub_cnt_r;
    logic            last_bit_s;
    logic            chain_full_s;

    logic            s_ready_r;
    logic            cfg_si_r;
    logic            cfg_en_r;
    logic [DW-1:0]   rb_data_r;
    logic            rb_valid_r;
    logic            busy_r;
    logic            done_r;

    // Next-state and next transmit-word decode.
    always_comb begin
        state_nxt_s  = state_r;
        tx_nxt_s     = tx_r;
        last_bit_s   = (sub_cnt_r == SW'(DW - 1));
        // Counter value after the current shift; the chain is full when it
        // reaches CHAIN_LEN, so the counter never has to wrap.
        chain_full_s = ((bit_cnt_r + CW'(1)) == CW'(CHAIN_LEN));
        // Readback register after taking in the current tail bit.
        rx_cat_s     = {rx_r, cfg_so};
        rx_shift_s   = rx_cat_s[DW-1:0];
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s = WAIT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WAIT: begin
                if (s_valid) begin
                    state_nxt_s = SHIFT;
                    tx_nxt_s    = s_data;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            SHIFT: begin
                tx_nxt_s = tx_r << 1;
                if (last_bit_s) begin
                    if (chain_full_s) begin
                        state_nxt_s = FIN;
                    end else begin
                        state_nxt_s = WAIT;
                    end
                end else begin
                    state_nxt_s = SHIFT;
                end
            end
            FIN: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, shift registers and bit counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            tx_r      <= DW'(0);
            rx_r      <= DW'(0);
            bit_cnt_r <= CW'(0);
            sub_cnt_r <= SW'(0);
        end else begin
            state_r <= state_nxt_s;
            tx_r    <= tx_nxt_s;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        bit_cnt_r <= CW'(0);
                        sub_cnt_r <= SW'(0);
                    end
                end
                WAIT: begin
                    if (s_valid) begin
                        sub_cnt_r <= SW'(0);
                    end
                end
                SHIFT: begin
                    rx_r      <= rx_shift_s;
                    bit_cnt_r <= bit_cnt_r + CW'(1);
                    sub_cnt_r <= sub_cnt_r + SW'(1);
                end
                default: begin
                end
            endcase
        end
    end

    // Registered outputs, decoded from the next state so the chain enable
    // and serial data come straight from flops (glitch-free clock gate).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_ready_r  <= 1'b0;
            cfg_si_r   <= 1'b0;
            cfg_en_r   <= 1'b0;
            rb_data_r  <= DW'(0);
            rb_valid_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            s_ready_r  <= (state_nxt_s == WAIT);
            cfg_en_r   <= (state_nxt_s == SHIFT);
            cfg_si_r   <= (state_nxt_s == SHIFT) ? tx_nxt_s[DW-1] : 1'b0;
            busy_r     <= (state_nxt_s != IDLE);
            done_r     <= (state_nxt_s == FIN);
            rb_valid_r <= (state_r == SHIFT) && last_bit_s;
            if ((state_r == SHIFT) && last_bit_s) begin
                rb_data_r <= rx_shift_s;
            end
        end
    end

    assign s_ready  = s_ready_r;
    assign cfg_si   = cfg_si_r;
    assign cfg_en   = cfg_en_r;
    assign rb_data  = rb_data_r;
    assign rb_valid = rb_valid_r;
    assign busy     = busy_r;
    assign done     = done_r;

endmodule

// File: doc/cfg_chain_loader.md
# cfg_chain_loader

Configuration-chain driver for the fabric: accepts bitstream words from the host over a valid/ready stream, serializes them onto the serial input of the daisy-chained configuration shift registers (connection boxes, switch boxes, LUTs), and asserts the chain shift enable only while a valid bit is presented. The previous chain contents that emerge at the chain tail are reassembled into readback words, so the host gets the old configuration back in the same pass. It sits between the host bitstream port and the head/tail of the configuration chain.

## Interface
Parameters:
- DW, 8, bitstream word width in bits.
- CHAIN_LEN, 64, total chain length in bits; must be a non-zero multiple of DW.

Ports:
- clk  input  1  system clock; the chain also shifts on rising clk when cfg_en=1.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to begin a full chain load; ignored while busy=1.
- s_data  input  DW  bitstream word; bit DW-1 is sent first.
- s_valid  input  1  s_data valid.
- s_ready  output  1  loader accepts s_data this cycle.
- cfg_si  output  1  serial data to chain head.
- cfg_en  output  1  chain shift enable (feeds chain clock gate).
- cfg_so  input  1  serial data from chain tail.
- rb_data  output  DW  readback word; first bit out of chain in bit DW-1.
- rb_valid  output  1  one-cycle pulse, rb_data valid; no backpressure.
- busy  output  1  load in progress.
- done  output  1  one-cycle pulse, all CHAIN_LEN bits shifted.

## Operation
- FSM states: IDLE, WAIT, SHIFT, FIN.
- IDLE: busy=0, s_ready=0, cfg_en=0. start=1 -> WAIT, clear bit counter.
- WAIT: busy=1, s_ready=1, cfg_en=0. On s_valid=1 (handshake), load s_data into tx shift register -> SHIFT. s_valid=0 -> stay in WAIT (chain stalls, no error, no timeout).
- SHIFT: s_ready=0, cfg_en=1, cfg_si=tx[DW-1]. On each edge: tx shifts left by one, cfg_so shifted into rx LSB, bit counter +1. After DW shifts: if counter==CHAIN_LEN -> FIN, else -> WAIT.
- rb_valid pulses in the cycle following the DW-th shift of each word (the WAIT or FIN cycle), with rb_data = rx; CHAIN_LEN/DW pulses per load.
- FIN: done=1 for one cycle, busy=1, then -> IDLE.
- cfg_si driven 0 whenever cfg_en=0.
- Bit counter width clog2(CHAIN_LEN+1); never wraps within a load; reset to 0 on start.
- First bit sent ends at the chain tail after CHAIN_LEN shifts; first bit read back is the old tail bit.
- start asserted in FIN or any busy state: ignored, not queued.
- rst_n low at any time, including mid-SHIFT: immediately returns to IDLE, cfg_en=0; chain left partially shifted; host must issue a full new load.

## Timing
- Reset values: s_ready=0, cfg_si=0, cfg_en=0, rb_data=0, rb_valid=0, busy=0, done=0; all outputs registered or decoded from registered state only.
- start sampled at edge 0 -> WAIT in cycle 1, busy=1 from cycle 1.
- Per word: 1 WAIT cycle minimum + DW SHIFT cycles; with s_valid held high, throughput DW bits per DW+1 cycles.
- DW=8, CHAIN_LEN=64, s_valid held: SHIFT in cycles 2-9, 11-18, ..., 65-72; rb_valid in cycles 10, 19, ..., 73; done in cycle 73; busy=0 from cycle 74.
- cfg_so sampled on the same edge the chain shifts (cfg_en=1).

## Test plan
- Reset then idle: no start -> all outputs 0, cfg_en never high.
- Single load, DW=8, CHAIN_LEN=64, words 0x01..0x08, s_valid held, 64-bit behavioural chain model preloaded 0xA5 per byte -> chain holds 0x01..0x08 (0x01 at tail), rb_data=0xA5 eight times at cycles 10..73, done at cycle 73, exactly 64 cfg_en cycles.
- Stall: drop s_valid for 5 cycles before word 3 -> loader waits in WAIT with cfg_en=0, final chain contents identical, done delayed 5 cycles.
- Back-to-back loads: second load of 0xFF words right after done -> readback returns 0x01..0x08 in order.
- start pulsed during SHIFT and during FIN -> ignored; exactly one done pulse, 64 shifts.
- rst_n asserted mid-SHIFT of word 4 -> outputs at reset values immediately; subsequent full load gives correct chain contents.
